// File: rtl/axis_opt_unpack_if.sv
// AXI-Stream style bundle (data, valid, last, ready) shared by the wide input
// and narrow output sides of axis_opt_unpack.
interface axis_opt_unpack_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_opt_unpack.sv
// Splits each WIDTH*RATIO input word into RATIO output beats of WIDTH bits.
// Optional input skid register enabled by macro AXIS_OPT_UNPACK_SKID_EN.
module axis_opt_unpack #(
  parameter int WIDTH     = 32,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                clk,
  input logic                rst,
  axis_opt_unpack_if.slave   s_rx,
  axis_opt_unpack_if.master  m_tx
);
  localparam int            IW       = $clog2(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  logic [WIDTH*RATIO-1:0] word_q, word_d;
  logic                   valid_q, valid_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   last_q, last_d;

  logic                   last_beat_s;
  logic                   consume_s;
  logic                   main_free_s;
  logic                   s_ready_s;
  logic                   accept_s;
  logic [IW-1:0]          sel_s;
  logic [WIDTH-1:0]       slices_s [RATIO];

`ifdef AXIS_OPT_UNPACK_SKID_EN
  logic [WIDTH*RATIO-1:0] skid_word_q, skid_word_d;
  logic                   skid_last_q, skid_last_d;
  logic                   skid_valid_q, skid_valid_d;
`endif

  // Handshake qualifiers; ready is forced low while reset is held.
  always_comb begin
    last_beat_s = valid_q && (idx_q == LAST_IDX);
    consume_s   = valid_q && m_tx.tready;
    main_free_s = !valid_q || (m_tx.tready && last_beat_s);
`ifdef AXIS_OPT_UNPACK_SKID_EN
    s_ready_s   = rst && !skid_valid_q;
`else
    s_ready_s   = rst && main_free_s;
`endif
    accept_s    = s_rx.tvalid && s_ready_s;
  end

  // Next-state for the word register, beat index and optional skid stage.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef AXIS_OPT_UNPACK_SKID_EN
    skid_word_d  = skid_word_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    // A parked word always goes ahead of anything newer to preserve order.
    if (skid_valid_q && main_free_s) begin
      word_d       = skid_word_q;
      last_d       = skid_last_q;
      valid_d      = 1'b1;
      idx_d        = '0;
      skid_valid_d = 1'b0;
    end else if (accept_s && main_free_s) begin
      word_d  = s_rx.tdata;
      last_d  = s_rx.tlast;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (accept_s) begin
      skid_word_d  = s_rx.tdata;
      skid_last_d  = s_rx.tlast;
      skid_valid_d = 1'b1;
      if (consume_s) begin
        idx_d = idx_q + IW'(1);
      end else begin
        idx_d = idx_q;
      end
    end else if (consume_s) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      valid_d = valid_q;
    end
`else
    if (accept_s) begin
      word_d  = s_rx.tdata;
      last_d  = s_rx.tlast;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (consume_s) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      valid_d = valid_q;
    end
`endif
  end

  // Control state resets; data registers simply hold during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
`ifdef AXIS_OPT_UNPACK_SKID_EN
      skid_valid_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      word_q  <= word_d;
`ifdef AXIS_OPT_UNPACK_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      skid_last_q  <= skid_last_d;
`endif
    end
  end

  // Slice selection honouring the configured beat order.
  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      slices_s[i] = word_q[i*WIDTH +: WIDTH];
    end
    if (MSB_FIRST) begin
      sel_s = LAST_IDX - idx_q;
    end else begin
      sel_s = idx_q;
    end
  end

  assign s_rx.tready = s_ready_s;
  assign m_tx.tvalid = valid_q;
  assign m_tx.tlast  = last_beat_s && last_q;
  assign m_tx.tdata  = slices_s[sel_s];

endmodule

// File: doc/axis_opt_unpack.md
AXIS_OPT_UNPACK -- requirements
Module: axis_opt_unpack

Interface
REQ-001 Parameter WIDTH, default 32: output beat width in bits.
REQ-002 Parameter RATIO, default 4: output beats per input word; legal range 2..16.
REQ-003 Parameter MSB_FIRST, default 0: 0 emits slice [WIDTH-1:0] first; 1 emits the top slice first.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 s_rx_tdata  input  WIDTH*RATIO  wide input word.
REQ-007 s_rx_tvalid  input  1  input word valid.
REQ-008 s_rx_tlast  input  1  input word ends a packet.
REQ-009 s_rx_tready  output  1  input word accepted when s_rx_tvalid && s_rx_tready at a clock edge.
REQ-010 m_tx_tdata  output  WIDTH  current output slice.
REQ-011 m_tx_tvalid  output  1  output beat valid.
REQ-012 m_tx_tlast  output  1  last beat of a packet.
REQ-013 m_tx_tready  input  1  output beat consumed when m_tx_tvalid && m_tx_tready at a clock edge.

Function
REQ-014 The block SHALL hold one word register, a valid flag and a beat index idx (0..RATIO-1), forming states EMPTY (valid=0) and SHIFT (valid=1).
REQ-015 An accepted word SHALL load the register, set valid, clear idx and capture tlast; first beat appears on m_tx the cycle after acceptance (latency 1).
REQ-016 m_tx_tdata SHALL be slice idx (MSB_FIRST=0) or slice RATIO-1-idx (MSB_FIRST=1); m_tx_tvalid = valid.
REQ-017 A consumed beat with idx<RATIO-1 SHALL increment idx; with idx=RATIO-1 SHALL clear valid unless a new word is accepted the same cycle.
REQ-018 s_rx_tready SHALL equal ~valid || (m_tx_tready && idx==RATIO-1), so back-to-back words stream with no bubble.
REQ-019 Simultaneous last-beat consume and new-word accept SHALL load the new word with idx=0 and valid kept 1.
REQ-020 m_tx_tlast SHALL be 1 only when idx==RATIO-1 and the captured tlast is 1.
REQ-021 m_tx_tdata/m_tx_tlast SHALL stay stable while m_tx_tvalid=1 and m_tx_tready=0.
REQ-022 Throughput SHALL be one beat per cycle when m_tx_tready stays high; no beat is dropped or duplicated.

Reset
REQ-023 While rst=0 at a clock edge: valid<=0, idx<=0, skid valid<=0; m_tx_tvalid=0, m_tx_tlast=0.
REQ-024 s_rx_tready SHALL be 0 while rst=0 and 1 the first cycle after release.
REQ-025 Reset mid-word SHALL discard remaining beats; data register contents need no reset.

Configuration
REQ-026 Macro AXIS_OPT_UNPACK_SKID_EN defined: a one-word skid register SHALL sit at the input; s_rx_tready = ~skid_valid (registered, no combinational path from m_tx_tready); an accepted word goes to the main register if REQ-018 condition holds, else to the skid, which drains to the main register first; order preserved, latency unchanged.
REQ-027 Macro undefined: no skid register; s_rx_tready per REQ-018.

Verification
REQ-028 WIDTH=8,RATIO=4, word 0x44332211 tlast=1, m_tx_tready=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, tlast only on 0x44.
REQ-029 MSB_FIRST=1, same word -> 0x44,0x33,0x22,0x11, tlast on 0x11.
REQ-030 Two words back-to-back, tvalid held, m_tx_tready=1 -> 8 beats with no gap; s_rx_tready high only on cycles idx=3 (and initially).
REQ-031 m_tx_tready toggled 1,0,1,0 during a word -> each beat held stable while stalled; no loss or repeat.
REQ-032 rst=0 asserted after 2 beats consumed -> m_tx_tvalid=0 next cycle; after release next word starts at slice 0.
REQ-033 SKID_EN, m_tx_tready=0 for 10 cycles while 2 words offered -> exactly one extra word accepted, s_rx_tready then 0; release -> 8 beats in order.
